// File: rtl/int_sop_n_dspchain.sv
// rtl/int_sop_n_dspchain.sv - N-lane sum-of-products DSP slice with cascade chain and counted accumulate
// Ports: clk; reset (async, active-low); in_valid qualifies x, y, mode_sigs;
//   mode_sigs[0] signed operands, [1] accumulate enable, [2] chainin enable;
//   x/y packed lane operands (lane i at [i*AW +: AW] / [i*BW +: BW]); chainin cascade input;
//   out_valid, result (registered sum), chainout (= result), acc_done (last sample of a window).
// Optional: SOP_SATURATE_EN clamps the S3 sum to the signed/unsigned CW range instead of wrapping.
module int_sop_n_dspchain #(
    parameter int N_PROD  = 2,
    parameter int AW      = 18,
    parameter int BW      = 19,
    parameter int CW      = 37,
    parameter int ACC_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [2:0]           mode_sigs,
    input  logic [N_PROD*AW-1:0] x,
    input  logic [N_PROD*BW-1:0] y,
    input  logic [CW-1:0]        chainin,
    output logic                 out_valid,
    output logic [CW-1:0]        result,
    output logic [CW-1:0]        chainout,
    output logic                 acc_done
);
    localparam int CNTW = $clog2(ACC_LEN);

    // S1: input capture; data loads every cycle, the valid bit qualifies it
    logic                 r1_valid;
    logic [2:0]           r1_mode;
    logic [N_PROD*AW-1:0] r1_x;
    logic [N_PROD*BW-1:0] r1_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r1_valid <= 1'b0;
            r1_mode  <= '0;
            r1_x     <= '0;
            r1_y     <= '0;
        end else begin
            r1_valid <= in_valid;
            r1_mode  <= mode_sigs;
            r1_x     <= x;
            r1_y     <= y;
        end
    end

    // S2: per-lane products. Operands are extended to CW (sign or zero) so the
    // low CW bits of the product are the exact product for either signedness.
    logic [CW-1:0] w_prod [N_PROD];

    for (genvar g = 0; g < N_PROD; g++) begin : g_lane
        logic [AW-1:0] w_xl;
        logic [BW-1:0] w_yl;
        logic [CW-1:0] w_xe;
        logic [CW-1:0] w_ye;
        assign w_xl      = r1_x[g*AW +: AW];
        assign w_yl      = r1_y[g*BW +: BW];
        assign w_xe      = {{(CW-AW){r1_mode[0] & w_xl[AW-1]}}, w_xl};
        assign w_ye      = {{(CW-BW){r1_mode[0] & w_yl[BW-1]}}, w_yl};
        assign w_prod[g] = w_xe * w_ye;
    end

    logic          r2_valid;
    logic          r2_acc_en;
    logic          r2_chain_en;
    logic [CW-1:0] r2_p [N_PROD];
`ifdef SOP_SATURATE_EN
    logic          r2_sgn;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r2_valid    <= 1'b0;
            r2_acc_en   <= 1'b0;
            r2_chain_en <= 1'b0;
`ifdef SOP_SATURATE_EN
            r2_sgn      <= 1'b0;
`endif
            for (int i = 0; i < N_PROD; i++) begin
                r2_p[i] <= '0;
            end
        end else begin
            r2_valid    <= r1_valid;
            r2_acc_en   <= r1_mode[1];
            r2_chain_en <= r1_mode[2];
`ifdef SOP_SATURATE_EN
            r2_sgn      <= r1_mode[0];
`endif
            for (int i = 0; i < N_PROD; i++) begin
                r2_p[i] <= w_prod[i];
            end
        end
    end

    // S3: sum of products plus optional chainin (taken live, aligned with an
    // upstream slice's result register) plus optional accumulator.
    logic [CW-1:0]   r_acc;
    logic [CNTW-1:0] r_cnt;
    logic [CW-1:0]   w_sum;

`ifdef SOP_SATURATE_EN
    localparam int GW = CW + $clog2(N_PROD + 2) + 1;
    logic [GW-1:0] w_wide;

    function automatic logic [GW-1:0] f_ext(input logic [CW-1:0] v, input logic s);
        return {{(GW-CW){s & v[CW-1]}}, v};
    endfunction

    always_comb begin
        w_wide = '0;
        for (int i = 0; i < N_PROD; i++) begin
            w_wide = w_wide + f_ext(r2_p[i], r2_sgn);
        end
        if (r2_chain_en) w_wide = w_wide + f_ext(chainin, r2_sgn);
        if (r2_acc_en)   w_wide = w_wide + f_ext(r_acc, r2_sgn);
        w_sum = w_wide[CW-1:0];
        if (r2_sgn) begin
            // out of range when the guard bits are not all copies of the sign
            if (w_wide[GW-1:CW-1] != {(GW-CW+1){w_wide[GW-1]}}) begin
                w_sum = w_wide[GW-1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
            end
        end else if (w_wide[GW-1:CW] != '0) begin
            w_sum = '1;
        end
    end
`else
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_PROD; i++) begin
            w_sum = w_sum + r2_p[i];
        end
        if (r2_chain_en) w_sum = w_sum + chainin;
        if (r2_acc_en)   w_sum = w_sum + r_acc;
    end
`endif

    logic          r_out_valid;
    logic          r_acc_done;
    logic [CW-1:0] r_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_acc_done  <= 1'b0;
            r_result    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (!r2_valid) begin
            r_out_valid <= 1'b0;
            r_acc_done  <= 1'b0;
        end else if (!r2_acc_en) begin
            // a plain sample also abandons any partial window
            r_result    <= w_sum;
            r_out_valid <= 1'b1;
            r_acc_done  <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (r_cnt == CNTW'(ACC_LEN - 1)) begin
            r_result    <= w_sum;
            r_out_valid <= 1'b1;
            r_acc_done  <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            r_acc       <= w_sum;
            r_cnt       <= r_cnt + 1'b1;
            r_out_valid <= 1'b0;
            r_acc_done  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign acc_done  = r_acc_done;
    assign result    = r_result;
    assign chainout  = r_result;

endmodule

// File: tb/tb_int_sop_n_dspchain.sv
// tb/tb_int_sop_n_dspchain.sv - directed self-checking bench for int_sop_n_dspchain (two cascaded slices)
module tb_int_sop_n_dspchain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        a_valid = 1'b0;
    logic [2:0]  a_mode = '0;
    logic [35:0] a_x = '0;
    logic [37:0] a_y = '0;
    logic [36:0] a_chain = '0;
    logic        a_ov;
    logic [36:0] a_res;
    logic [36:0] a_co;
    logic        a_done;

    logic        b_valid = 1'b0;
    logic [2:0]  b_mode = '0;
    logic [35:0] b_x = '0;
    logic [37:0] b_y = '0;
    logic        b_ov;
    logic [36:0] b_res;
    logic [36:0] b_co;
    logic        b_done;

    int n_checks = 0;
    int n_errors = 0;

    int          a_pulses = 0;
    logic [36:0] a_last = '0;
    logic        a_last_done = 1'b0;
    int          b_pulses = 0;
    int          b_first = 0;
    int          b_lastc = 0;
    int          cyc = 0;
    logic        chain_on = 1'b0;

`ifdef SOP_SATURATE_EN
    localparam logic [63:0] EXP_OVF_U = 64'h1F_FFFF_FFFF;
    localparam logic [63:0] EXP_OVF_S = 64'h10_0000_0000;
`else
    localparam logic [63:0] EXP_OVF_U = 64'h1F_FFE8_0001;
    localparam logic [63:0] EXP_OVF_S = 64'h4_0000;
`endif

    int_sop_n_dspchain u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_valid),
        .mode_sigs (a_mode),
        .x         (a_x),
        .y         (a_y),
        .chainin   (a_chain),
        .out_valid (a_ov),
        .result    (a_res),
        .chainout  (a_co),
        .acc_done  (a_done)
    );

    int_sop_n_dspchain u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_valid),
        .mode_sigs (b_mode),
        .x         (b_x),
        .y         (b_y),
        .chainin   (a_co),
        .out_valid (b_ov),
        .result    (b_res),
        .chainout  (b_co),
        .acc_done  (b_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_ov) begin
            a_pulses++;
            a_last = a_res;
            a_last_done = a_done;
        end
        if (b_ov) begin
            // sample j feeds lane0 x=j+1, so each slice sums 5+3j; b adds a's chainout
            if (chain_on) chk("chain_b_res", b_res, 64'(2 * (5 + 3 * b_pulses)));
            if (b_pulses == 0) b_first = cyc;
            b_lastc = cyc;
            b_pulses++;
        end
        cyc++;
    end

    task automatic set_a(input logic v, input logic [2:0] m, input logic [17:0] x1, input logic [17:0] x0,
                         input logic [18:0] y1, input logic [18:0] y0, input logic [36:0] ch);
        a_valid = v;
        a_mode  = m;
        a_x     = {x1, x0};
        a_y     = {y1, y0};
        a_chain = ch;
    endtask

    task automatic send1(input string tag, input logic [2:0] m, input logic [17:0] x1, input logic [17:0] x0,
                         input logic [18:0] y1, input logic [18:0] y0, input logic [36:0] ch,
                         input logic [63:0] exp);
        @(negedge clk); set_a(1'b1, m, x1, x0, y1, y0, ch);
        @(negedge clk); a_valid = 1'b0;
        @(negedge clk); chk({tag, "_early"}, 64'(a_ov), 64'd0);
        @(negedge clk);
        chk({tag, "_ov"}, 64'(a_ov), 64'd1);
        chk({tag, "_res"}, 64'(a_res), exp);
        chk({tag, "_co"}, 64'(a_co), exp);
    endtask

    task automatic burst(input int n, input int gap, input logic [2:0] m, input logic [17:0] x1,
                         input logic [17:0] x0, input logic [18:0] y1, input logic [18:0] y0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); set_a(1'b1, m, x1, x0, y1, y0, '0);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk); a_valid = 1'b0;
            end
        end
        @(negedge clk); a_valid = 1'b0;
    endtask

    task automatic settle_clr();
        repeat (6) @(negedge clk);
        a_pulses    = 0;
        a_last      = '0;
        a_last_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held while inputs toggle
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_a(1'b1, 3'($urandom), 18'($urandom), 18'($urandom), 19'($urandom), 19'($urandom), 37'($urandom));
            b_valid = 1'b1;
            b_mode  = 3'($urandom);
            b_x     = 36'($urandom);
            b_y     = 38'($urandom);
        end
        chk("rst_res", 64'(a_res), 64'd0);
        chk("rst_ov", 64'(a_ov), 64'd0);
        chk("rst_co", 64'(a_co), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_b_res", 64'(b_res), 64'd0);
        @(negedge clk);
        set_a(1'b0, '0, '0, '0, '0, '0, '0);
        b_valid = 1'b0;
        reset = 1'b1;
        settle_clr();

        // basic sum: 3*5 + 2*4 = 23, chainin 7 only when mode[2]
        send1("basic", 3'b000, 18'd3, 18'd2, 19'd5, 19'd4, 37'd7, 64'd23);
        send1("chainin", 3'b100, 18'd3, 18'd2, 19'd5, 19'd4, 37'd7, 64'd30);

        // signed: -2*3 + 1*-1 = -7; unsigned same bits: 262142*3 + 524287
        send1("signed", 3'b001, 18'd1, 18'h3FFFE, 19'h7FFFF, 19'd3, '0, 64'h1F_FFFF_FFF9);
        send1("unsigned", 3'b000, 18'd1, 18'h3FFFE, 19'h7FFFF, 19'd3, '0, 64'd1310713);
        settle_clr();

        // accumulate: 4 samples of 2*3 + 1*4 = 10, back-to-back then with gaps
        burst(4, 0, 3'b010, 18'd2, 18'd1, 19'd3, 19'd4);
        repeat (6) @(negedge clk);
        chk("acc_pulses", 64'(a_pulses), 64'd1);
        chk("acc_res", 64'(a_last), 64'd40);
        chk("acc_done", 64'(a_last_done), 64'd1);
        settle_clr();
        burst(4, 2, 3'b010, 18'd2, 18'd1, 19'd3, 19'd4);
        repeat (6) @(negedge clk);
        chk("accgap_pulses", 64'(a_pulses), 64'd1);
        chk("accgap_res", 64'(a_last), 64'd40);
        chk("accgap_done", 64'(a_last_done), 64'd1);
        settle_clr();

        // abort: 2 accumulate samples then a plain sample of 1*3 + 1*2 = 5
        burst(2, 0, 3'b010, 18'd2, 18'd1, 19'd3, 19'd4);
        burst(1, 0, 3'b000, 18'd1, 18'd1, 19'd3, 19'd2);
        repeat (6) @(negedge clk);
        chk("abort_pulses", 64'(a_pulses), 64'd1);
        chk("abort_res", 64'(a_last), 64'd5);
        chk("abort_done", 64'(a_last_done), 64'd0);
        settle_clr();
        burst(4, 0, 3'b010, 18'd0, 18'd1, 19'd0, 19'd1);
        repeat (6) @(negedge clk);
        chk("after_abort_pulses", 64'(a_pulses), 64'd1);
        chk("after_abort_res", 64'(a_last), 64'd4);
        chk("after_abort_done", 64'(a_last_done), 64'd1);
        settle_clr();

        // reset mid-window discards 3 partial samples
        burst(3, 0, 3'b010, 18'd2, 18'd1, 19'd3, 19'd4);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_res", 64'(a_res), 64'd0);
        chk("midrst_ov", 64'(a_ov), 64'd0);
        reset = 1'b1;
        settle_clr();
        burst(4, 0, 3'b010, 18'd0, 18'd1, 19'd0, 19'd1);
        repeat (6) @(negedge clk);
        chk("postrst_pulses", 64'(a_pulses), 64'd1);
        chk("postrst_res", 64'(a_last), 64'd4);
        settle_clr();

        // overflow extremes
        send1("ovf_u", 3'b100, 18'h3FFFF, 18'h3FFFF, 19'h7FFFF, 19'h7FFFF, 37'h1F_FFFF_FFFF, EXP_OVF_U);
        send1("ovf_s", 3'b101, 18'h20000, 18'h20000, 19'h3FFFF, 19'h3FFFF, 37'h10_0000_0000, EXP_OVF_S);
        settle_clr();

        // cascade: b gets each sample one cycle after a, so a's chainout lines up
        chain_on = 1'b1;
        b_pulses = 0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) set_a(1'b1, 3'b000, 18'd1, 18'(k + 1), 19'd2, 19'd3, '0);
            else a_valid = 1'b0;
            if (k >= 1) begin
                b_valid = 1'b1;
                b_mode  = 3'b100;
                b_x     = {18'd1, 18'(k)};
                b_y     = {19'd2, 19'd3};
            end else begin
                b_valid = 1'b0;
            end
        end
        @(negedge clk); b_valid = 1'b0;
        repeat (6) @(negedge clk);
        chain_on = 1'b0;
        chk("chain_pulses", 64'(b_pulses), 64'd8);
        chk("chain_nobubble", 64'(b_lastc - b_first), 64'd7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
